// File: rtl/tuman_conf_pkg.sv
// Shared definitions for the TuMan32 configuration-port loader.
package tuman_conf_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OP_WR_ITCM = 8'h01;
    localparam logic [BYTE_W-1:0] OP_WR_DTCM = 8'h02;
    localparam logic [BYTE_W-1:0] OP_RD_ITCM = 8'h03;
    localparam logic [BYTE_W-1:0] OP_RD_DTCM = 8'h04;
    localparam logic [BYTE_W-1:0] OP_SEL_SET = 8'h05;
    localparam logic [BYTE_W-1:0] OP_SEL_CLR = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/tuman_conf_shreg.sv
// 4-byte MSB-first shift register with byte counter; shifts bytes in
// (address / write data) or, after a parallel load, shifts them out (response).
module tuman_conf_shreg
    import tuman_conf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_o
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    // Clear restarts the byte count only; load restarts it with a new word.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (load_i) begin
            word_d = word_i;
            cnt_d  = 2'd0;
        end else if (shift_i) begin
            word_d = {word_q[DATA_W-BYTE_W-1:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // Word and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign byte_o = word_q[DATA_W-1 -: BYTE_W];
    assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/tuman_conf_loader.sv
// Byte-stream command parser driving the TuMan32 ITCM/DTCM conf_* port.
module tuman_conf_loader
    import tuman_conf_pkg::*;
#(
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned TIMEOUT   = 65535,
    parameter bit          SEL_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    input  logic              out_ready,
    output logic              conf_sel_dtcm,
    output logic              conf_rden_itcm,
    output logic              conf_wren_itcm,
    output logic [ADDR_W-1:0] conf_addr_itcm,
    output logic [DATA_W-1:0] conf_wdata_itcm,
    input  logic [DATA_W-1:0] conf_rdata_itcm,
    output logic              conf_rden_dtcm,
    output logic              conf_wren_dtcm,
    output logic [ADDR_W-1:0] conf_addr_dtcm,
    output logic [DATA_W-1:0] conf_wdata_dtcm,
    input  logic [DATA_W-1:0] conf_rdata_dtcm,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    state_e            state_q, state_d;
    logic              rdy_q, sel_q, tgt_dtcm_q, rd_q;
    logic [7:0]        err_q;
    logic [15:0]       to_q;
    logic [1:0]        wcnt_q;
    logic [ADDR_W-1:0] addr_itcm_q, addr_dtcm_q;
    logic [DATA_W-1:0] wdata_itcm_q, wdata_dtcm_q;

    logic              accept, idle_acc, op_mem, op_bad, in_cmd, tmo, wait_done;
    logic              addr_last, wdata_last, rsp_last;
    logic [ADDR_W-1:0] addr_word, addr_nxt;
    logic [DATA_W-1:0] wdata_word, wdata_nxt, rsp_word, rdata_sel;
    logic [BYTE_W-1:0] addr_byte, wdata_byte;
    logic              unused_ok;

    assign accept    = in_valid & in_ready;
    assign idle_acc  = accept && (state_q == ST_IDLE);
    assign op_mem    = (in_data >= OP_WR_ITCM) && (in_data <= OP_RD_DTCM);
    assign op_bad    = !op_mem && (in_data != OP_SEL_SET) && (in_data != OP_SEL_CLR);
    assign in_cmd    = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign tmo       = in_cmd && !accept && (to_q == 16'(TIMEOUT - 1));
    assign wait_done = (wcnt_q == 2'(READ_LAT - 1));
    // Word values as they will be once the byte being accepted is shifted in.
    assign addr_nxt  = {addr_word[ADDR_W-BYTE_W-1:0], in_data};
    assign wdata_nxt = {wdata_word[DATA_W-BYTE_W-1:0], in_data};
    assign rdata_sel = tgt_dtcm_q ? conf_rdata_dtcm : conf_rdata_itcm;
    assign unused_ok = ^{addr_byte, wdata_byte, rsp_word};

    tuman_conf_shreg u_addr (
        .clk_i (clk), .rst_ni (resetn), .clr_i (idle_acc), .load_i (1'b0), .word_i ('0),
        .shift_i (accept && (state_q == ST_ADDR)), .byte_i (in_data),
        .word_o (addr_word), .byte_o (addr_byte), .last_o (addr_last)
    );

    tuman_conf_shreg u_wdata (
        .clk_i (clk), .rst_ni (resetn), .clr_i (idle_acc), .load_i (1'b0), .word_i ('0),
        .shift_i (accept && (state_q == ST_DATA)), .byte_i (in_data),
        .word_o (wdata_word), .byte_o (wdata_byte), .last_o (wdata_last)
    );

    tuman_conf_shreg u_rsp (
        .clk_i (clk), .rst_ni (resetn), .clr_i (1'b0),
        .load_i ((state_q == ST_WAIT) && wait_done), .word_i (rdata_sel),
        .shift_i ((state_q == ST_RESP) && out_ready), .byte_i ('0),
        .word_o (rsp_word), .byte_o (out_data), .last_o (rsp_last)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a timeout in ADDR/DATA drops the partial command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && op_mem) state_d = ST_ADDR;
            ST_ADDR:  if (accept && addr_last) state_d = rd_q ? ST_READ : ST_DATA;
                      else if (tmo)            state_d = ST_IDLE;
            ST_DATA:  if (accept && wdata_last) state_d = ST_WRITE;
                      else if (tmo)             state_d = ST_IDLE;
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  if (wait_done) state_d = ST_RESP;
            ST_RESP:  if (out_ready && rsp_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode; strobes depend only on registered state so reset keeps them low.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        conf_wren_itcm = 1'b0;
        conf_wren_dtcm = 1'b0;
        conf_rden_itcm = 1'b0;
        conf_rden_dtcm = 1'b0;
        case (state_q)
            ST_IDLE, ST_ADDR, ST_DATA: in_ready = rdy_q;
            ST_WRITE: begin
                conf_wren_itcm = !tgt_dtcm_q;
                conf_wren_dtcm = tgt_dtcm_q;
            end
            ST_READ: begin
                conf_rden_itcm = !tgt_dtcm_q;
                conf_rden_dtcm = tgt_dtcm_q;
            end
            ST_RESP: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Control registers: command latch, sel, error and timeout/latency counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q      <= 1'b0;
            sel_q      <= SEL_RESET;
            tgt_dtcm_q <= 1'b0;
            rd_q       <= 1'b0;
            err_q      <= 8'd0;
            to_q       <= 16'd0;
            wcnt_q     <= 2'd0;
        end else begin
            rdy_q <= 1'b1;
            if (idle_acc && op_mem) begin
                tgt_dtcm_q <= (in_data == OP_WR_DTCM) || (in_data == OP_RD_DTCM);
                rd_q       <= (in_data == OP_RD_ITCM) || (in_data == OP_RD_DTCM);
            end
            if (idle_acc && (in_data == OP_SEL_SET)) sel_q <= 1'b1;
            if (idle_acc && (in_data == OP_SEL_CLR)) sel_q <= 1'b0;
            if (((idle_acc && op_bad) || tmo) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            to_q   <= (in_cmd && !accept) ? to_q + 16'd1 : 16'd0;
            wcnt_q <= ((state_q == ST_WAIT) && !wait_done) ? wcnt_q + 2'd1 : 2'd0;
        end
    end

    // Per-memory address/data; only the selected memory's outputs are updated.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_itcm_q  <= '0;
            addr_dtcm_q  <= '0;
            wdata_itcm_q <= '0;
            wdata_dtcm_q <= '0;
        end else if ((state_q == ST_ADDR) && accept && addr_last && rd_q) begin
            if (tgt_dtcm_q) addr_dtcm_q <= addr_nxt;
            else            addr_itcm_q <= addr_nxt;
        end else if ((state_q == ST_DATA) && accept && wdata_last) begin
            if (tgt_dtcm_q) begin
                addr_dtcm_q  <= addr_word;
                wdata_dtcm_q <= wdata_nxt;
            end else begin
                addr_itcm_q  <= addr_word;
                wdata_itcm_q <= wdata_nxt;
            end
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign err_cnt         = err_q;
    assign conf_sel_dtcm   = sel_q;
    assign conf_addr_itcm  = addr_itcm_q;
    assign conf_addr_dtcm  = addr_dtcm_q;
    assign conf_wdata_itcm = wdata_itcm_q;
    assign conf_wdata_dtcm = wdata_dtcm_q;

endmodule

// File: tb/tb_tuman_conf_loader.sv
// Bench for tuman_conf_loader: two instances (READ_LAT 1 and 3) fed the same byte stream.
module tb_tuman_conf_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic [31:0] mem_i, mem_d;

    always #5 clk = ~clk;

    logic        in_ready_w [2];
    logic        out_valid_w[2];
    logic [7:0]  out_data_w [2];
    logic        sel_w [2];
    logic        busy_w[2];
    logic [7:0]  err_w [2];
    logic        rden_i[2], wren_i[2], rden_d[2], wren_d[2];
    logic [31:0] addr_i[2], wdata_i[2], addr_d[2], wdata_d[2];
    logic [31:0] rdata_i[2], rdata_d[2];

    tuman_conf_loader #(.READ_LAT(1), .TIMEOUT(16), .SEL_RESET(1'b1)) dut_l1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_data(out_data_w[0]),
        .out_ready(out_ready), .conf_sel_dtcm(sel_w[0]),
        .conf_rden_itcm(rden_i[0]), .conf_wren_itcm(wren_i[0]),
        .conf_addr_itcm(addr_i[0]), .conf_wdata_itcm(wdata_i[0]), .conf_rdata_itcm(rdata_i[0]),
        .conf_rden_dtcm(rden_d[0]), .conf_wren_dtcm(wren_d[0]),
        .conf_addr_dtcm(addr_d[0]), .conf_wdata_dtcm(wdata_d[0]), .conf_rdata_dtcm(rdata_d[0]),
        .busy(busy_w[0]), .err_cnt(err_w[0])
    );

    tuman_conf_loader #(.READ_LAT(3), .TIMEOUT(16), .SEL_RESET(1'b1)) dut_l3 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_data(out_data_w[1]),
        .out_ready(out_ready), .conf_sel_dtcm(sel_w[1]),
        .conf_rden_itcm(rden_i[1]), .conf_wren_itcm(wren_i[1]),
        .conf_addr_itcm(addr_i[1]), .conf_wdata_itcm(wdata_i[1]), .conf_rdata_itcm(rdata_i[1]),
        .conf_rden_dtcm(rden_d[1]), .conf_wren_dtcm(wren_d[1]),
        .conf_addr_dtcm(addr_d[1]), .conf_wdata_dtcm(wdata_d[1]), .conf_rdata_dtcm(rdata_d[1]),
        .busy(busy_w[1]), .err_cnt(err_w[1])
    );

    // Memory models: data is valid only in the cycle exactly L cycles after rden.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int L = (g == 0) ? 1 : 3;
        logic [2:0] pi_q, pd_q;
        always @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                pi_q <= '0;
                pd_q <= '0;
            end else begin
                pi_q <= {pi_q[1:0], rden_i[g]};
                pd_q <= {pd_q[1:0], rden_d[g]};
            end
        end
        assign rdata_i[g] = pi_q[L-1] ? mem_i : 32'hA5A5_A5A5;
        assign rdata_d[g] = pd_q[L-1] ? mem_d : 32'h5A5A_5A5A;
    end

    int n_chk = 0, n_pass = 0;
    int wr_i_cnt[2], wr_d_cnt[2], rd_i_cnt[2], rd_d_cnt[2], rx_cnt[2];
    int excl_bad = 0;
    int exp_wi = 0, exp_wd = 0, exp_ri = 0, exp_rd = 0;
    logic [31:0] last_ai = '0, last_ad = '0;
    logic [7:0] sb0[$], sb1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired before the expected event", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strb(input int k);
        return {wren_i[k], wren_d[k], rden_i[k], rden_d[k]};
    endfunction

    // Monitors: strobe counts, exclusivity, and response bytes against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        for (int k = 0; k < 2; k++) begin
            if (wren_i[k]) wr_i_cnt[k]++;
            if (wren_d[k]) wr_d_cnt[k]++;
            if (rden_i[k]) rd_i_cnt[k]++;
            if (rden_d[k]) rd_d_cnt[k]++;
            if (int'(wren_i[k]) + int'(wren_d[k]) + int'(rden_i[k]) + int'(rden_d[k]) > 1)
                excl_bad++;
            if (out_valid_w[k] && out_ready) begin
                rx_cnt[k]++;
                if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                    fail_now($sformatf("rsp_unexpected%0d", k));
                end else begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("rsp_byte%0d", k), 32'(out_data_w[k]), 32'(e));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!(in_ready_w[0] && in_ready_w[1]) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) fail_now("in_ready_wait");
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_w[0] || busy_w[1] || sb0.size() != 0 || sb1.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) fail_now("idle_wait");
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or memory contents for a read
        logic [3:0]  exp_strb;  // {wren_itcm, wren_dtcm, rden_itcm, rden_dtcm}
    } vec_t;

    task automatic apply(input vec_t v);
        logic wr, dt;
        wr = v.exp_strb[3] | v.exp_strb[2];
        dt = v.exp_strb[2] | v.exp_strb[0];
        if (!wr) begin
            if (dt) mem_d = v.data;
            else    mem_i = v.data;
        end
        send(v.op);
        for (int i = 3; i >= 0; i--) send(v.addr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) send(v.data[i*8 +: 8]);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("strobe%0d op%h", k, v.op), 32'(strb(k)), 32'(v.exp_strb));
            chk($sformatf("addr_sel%0d", k), dt ? addr_d[k] : addr_i[k], v.addr);
            chk($sformatf("addr_hold%0d", k), dt ? addr_i[k] : addr_d[k], dt ? last_ai : last_ad);
            if (wr) chk($sformatf("wdata%0d", k), dt ? wdata_d[k] : wdata_i[k], v.data);
        end
        if (!wr) begin
            for (int i = 3; i >= 0; i--) begin
                sb0.push_back(v.data[i*8 +: 8]);
                sb1.push_back(v.data[i*8 +: 8]);
            end
        end
        if (dt) last_ad = v.addr;
        else    last_ai = v.addr;
        if (wr) begin
            if (dt) exp_wd++;
            else    exp_wi++;
        end else begin
            if (dt) exp_rd++;
            else    exp_ri++;
        end
        tick();
        for (int k = 0; k < 2; k++) chk($sformatf("strobe_off%0d", k), 32'(strb(k)), 32'h0);
        wait_idle();
    endtask

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, snap_wd;
        tbl[0] = '{8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1000};
        tbl[1] = '{8'h04, 32'h0000_0003, 32'h1234_5678, 4'b0001};
        tbl[2] = '{8'h03, 32'h0000_0007, 32'hCAFE_F00D, 4'b0010};
        tbl[3] = '{8'h02, 32'h0000_0044, 32'h55AA_55AA, 4'b0100};
        tbl[4] = '{8'h01, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1000};
        tbl[5] = '{8'h03, 32'h8000_0000, 32'hA1B2_C3D4, 4'b0010};
        tbl[6] = '{8'h04, 32'h0001_2345, 32'h0F1E_2D3C, 4'b0001};

        // Reset state
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        mem_i = '0; mem_d = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("rst_in_ready%0d", k), 32'(in_ready_w[k]), 32'h0);
        resetn = 1'b1;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rel_sel%0d", k), 32'(sel_w[k]), 32'h1);
            chk($sformatf("rel_busy%0d", k), 32'(busy_w[k]), 32'h0);
            chk($sformatf("rel_in_ready%0d", k), 32'(in_ready_w[k]), 32'h1);
            chk($sformatf("rel_err%0d", k), 32'(err_w[k]), 32'h0);
            chk($sformatf("rel_strobes%0d", k), 32'(strb(k)), 32'h0);
            chk($sformatf("rel_addr%0d", k), addr_i[k] | addr_d[k] | wdata_i[k] | wdata_d[k], 32'h0);
        end

        // Table-driven commands
        for (int n = 0; n < 7; n++) apply(tbl[n]);

        // Read with output back-pressure mid-stream
        base = rx_cnt[0];
        apply_stall: begin
            mem_d = 32'h1234_5678;
            send(8'h04);
            send(8'h00); send(8'h00); send(8'h00); send(8'h03);
            for (int k = 0; k < 2; k++) chk($sformatf("stall_rden%0d", k), 32'(strb(k)), 32'h1);
            for (int i = 3; i >= 0; i--) begin
                sb0.push_back(mem_d[i*8 +: 8]);
                sb1.push_back(mem_d[i*8 +: 8]);
            end
            exp_rd++;
            last_ad = 32'h3;
            t = 0;
            while (rx_cnt[0] < base + 2 && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) fail_now("stall_wait");
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("stall_valid", 32'(out_valid_w[0]), 32'h1);
                chk("stall_data", 32'(out_data_w[0]), 32'h56);
            end
            out_ready = 1'b1;
            wait_idle();
        end

        // Bad opcode, then a write that stalls and times out
        send(8'h7F);
        for (int k = 0; k < 2; k++) chk($sformatf("err_badop%0d", k), 32'(err_w[k]), 32'h1);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        repeat (8) tick();
        for (int k = 0; k < 2; k++) chk($sformatf("tmo_still_busy%0d", k), 32'(busy_w[k]), 32'h1);
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tmo_idle%0d", k), 32'(busy_w[k]), 32'h0);
            chk($sformatf("tmo_err%0d", k), 32'(err_w[k]), 32'h2);
            chk($sformatf("tmo_no_wren%0d", k), 32'(wr_d_cnt[k]), 32'(exp_wd));
        end
        apply('{8'h01, 32'h0000_0020, 32'h1357_9BDF, 4'b1000});

        // conf_sel_dtcm clear / set, changing on the accepting edge
        in_valid = 1'b1; in_data = 8'h06;
        #2;
        for (int k = 0; k < 2; k++) chk($sformatf("sel_pre_clr%0d", k), 32'(sel_w[k]), 32'h1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("sel_clr%0d", k), 32'(sel_w[k]), 32'h0);
        in_valid = 1'b1; in_data = 8'h05;
        #2;
        for (int k = 0; k < 2; k++) chk($sformatf("sel_pre_set%0d", k), 32'(sel_w[k]), 32'h0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("sel_set%0d", k), 32'(sel_w[k]), 32'h1);

        // Reset in the middle of a DTCM write's data phase
        send(8'h06);
        send(8'h02);
        send(8'h00); send(8'h00); send(8'h00); send(8'h40);
        send(8'h11); send(8'h22);
        for (int k = 0; k < 2; k++) chk($sformatf("mid_busy%0d", k), 32'(busy_w[k]), 32'h1);
        snap_wd = wr_d_cnt[0];
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mrst_busy%0d", k), 32'(busy_w[k]), 32'h0);
            chk($sformatf("mrst_in_ready%0d", k), 32'(in_ready_w[k]), 32'h0);
            chk($sformatf("mrst_sel%0d", k), 32'(sel_w[k]), 32'h1);
            chk($sformatf("mrst_err%0d", k), 32'(err_w[k]), 32'h0);
            chk($sformatf("mrst_addr_d%0d", k), addr_d[k], 32'h0);
        end
        repeat (3) tick();
        resetn = 1'b1;
        tick(); tick();
        last_ai = '0; last_ad = '0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mrst_rel_ready%0d", k), 32'(in_ready_w[k]), 32'h1);
            chk($sformatf("mrst_rel_strobes%0d", k), 32'(strb(k)), 32'h0);
        end
        chk("mrst_no_wren", 32'(wr_d_cnt[0]), 32'(snap_wd));
        apply('{8'h02, 32'h0000_0099, 32'h0BAD_CAFE, 4'b0100});

        // Strobe totals and exclusivity
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tot_wr_i%0d", k), 32'(wr_i_cnt[k]), 32'(exp_wi));
            chk($sformatf("tot_wr_d%0d", k), 32'(wr_d_cnt[k]), 32'(exp_wd));
            chk($sformatf("tot_rd_i%0d", k), 32'(rd_i_cnt[k]), 32'(exp_ri));
            chk($sformatf("tot_rd_d%0d", k), 32'(rd_d_cnt[k]), 32'(exp_rd));
        end
        chk("strobe_excl", 32'(excl_bad), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tuman_conf_loader.md
Name: tuman_conf_loader

Overview:
Host-side initiator for the TuMan32 configuration port. It parses a byte-stream command protocol, typically fed from a UART receiver. From those commands it drives the ITCM/DTCM conf_* write/read strobes and returns read data as a byte stream. It also controls conf_sel_dtcm, which holds the core in reset while memories are loaded. It sits outside TuMan32_top and connects port-for-port to its conf_* inputs and outputs.

Parameters:
READ_LAT, 1, cycles from conf_rden_* pulse to valid conf_rdata_*; legal range 1..3.
TIMEOUT, 65535, idle cycles allowed between bytes of one command before abort; 16-bit counter.
SEL_RESET, 1, reset value of conf_sel_dtcm (1 = core held in reset after power-up).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  command byte valid
in_data  in  8  command byte
in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
out_valid  out  1  response byte valid
out_data  out  8  response byte
out_ready  in  1  sink accepts response byte
conf_sel_dtcm  out  1  1 = core held in reset / DTCM owned by conf port
conf_rden_itcm, conf_wren_itcm  out  1 each  ITCM read/write strobes
conf_addr_itcm, conf_wdata_itcm  out  32 each  ITCM address/data
conf_rdata_itcm  in  32  ITCM read data
conf_rden_dtcm, conf_wren_dtcm  out  1 each  DTCM read/write strobes
conf_addr_dtcm, conf_wdata_dtcm  out  32 each  DTCM address/data
conf_rdata_dtcm  in  32  DTCM read data
busy  out  1  high in any state other than IDLE
err_cnt  out  8  saturating count of bad opcodes and timeouts

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE.
  - All strobes, out_valid, busy, err_cnt, addr and wdata registers are 0.
  - conf_sel_dtcm = SEL_RESET.
  - in_ready = 0 while in reset, 1 in IDLE after reset.
- Command format; multi-byte fields are big-endian (MSB first):
  - 0x01 write ITCM: addr[4], data[4]
  - 0x02 write DTCM: addr[4], data[4]
  - 0x03 read ITCM: addr[4]
  - 0x04 read DTCM: addr[4]
  - 0x05 set conf_sel_dtcm=1
  - 0x06 clear conf_sel_dtcm=0
- Address is forwarded verbatim as a word index; no shifting is applied.
- States: IDLE, ADDR, DATA, WRITE, READ, WAIT, RESP.
- IDLE:
  - Accepted opcode 0x01..0x04 -> latch target (ITCM/DTCM) and direction, go to ADDR, clear 2-bit byte counter.
  - Opcode 0x05/0x06 -> update conf_sel_dtcm on the next edge; stay in IDLE.
  - Any other opcode -> err_cnt+1 (saturating at 255); stay in IDLE.
- ADDR: shift in 4 bytes. After the 4th byte, go to DATA for writes, READ for reads.
- DATA: shift in 4 bytes, then go to WRITE.
- in_ready = 1 only in IDLE, ADDR and DATA.
- WRITE: exactly one cycle with the selected conf_wren_* = 1 and addr/wdata stable; then IDLE. Total accept-to-strobe latency is 1 cycle after the last data byte.
- READ: exactly one cycle with the selected conf_rden_* = 1; then WAIT.
- WAIT:
  - Counts READ_LAT-1 further cycles.
  - Captures the selected conf_rdata_* on the cycle exactly READ_LAT cycles after the rden cycle.
  - Then goes to RESP.
- RESP:
  - Presents 4 bytes MSB first, out_valid held with out_data stable until out_ready.
  - Advances one byte per handshake; after the 4th handshake goes to IDLE.
  - Back-to-back handshakes are allowed (1 byte/cycle).
- Strobes are mutually exclusive; ITCM and DTCM strobes are never high together. The unselected memory's addr/wdata outputs hold their last value.
- Timeout:
  - In ADDR/DATA, a 16-bit counter increments every cycle without an accepted byte and clears on each accepted byte.
  - On reaching TIMEOUT: abort to IDLE, err_cnt+1, no strobe issued.
  - No timeout applies in RESP; back-pressure may be indefinite.
- conf_sel_dtcm is never changed implicitly by read/write commands. Writes to DTCM while sel=0 are still issued; the host is responsible for ordering.
- Async reset mid-command: the partial command is discarded. No strobe may glitch high during or after reset release.

Decomposition:
- Shared package tuman_conf_pkg holds:
  - opcode constants OP_WR_ITCM..OP_SEL_CLR
  - FSM state enum
  - width localparams: ADDR_W=32, DATA_W=32, BYTE_W=8
- One natural sub-module: tuman_conf_shreg, a 4-byte MSB-first shift-in/shift-out register with byte counter. It is instantiated for addr, wdata and the rdata response.

Test Plan:
- Reset release -> conf_sel_dtcm=1, busy=0, in_ready=1, err_cnt=0, no strobes.
- Bytes 01 00 00 00 10 DE AD BE EF -> exactly one cycle of conf_wren_itcm=1, addr=0x00000010, wdata=0xDEADBEEF, one cycle after the last byte; DTCM strobes stay 0.
- Bytes 04 00 00 00 03 with conf_rdata_dtcm=0x12345678 at READ_LAT=1 (repeat at 3) -> one conf_rden_dtcm pulse; out bytes 12,34,56,78. Hold out_ready=0 for 5 cycles mid-stream -> out_data stable, no byte lost.
- Opcode 0x7F, then 02 + 3 address bytes and silence for TIMEOUT=16 cycles -> err_cnt=2, no wren, back to IDLE; next valid command executes normally.
- Byte 0x06 then 0x05 -> conf_sel_dtcm 1->0->1, each changing on the edge after acceptance.
- Assert resetn=0 during DATA of a DTCM write -> no conf_wren_dtcm ever asserted, state IDLE, conf_sel_dtcm=SEL_RESET.
